conv_result_sink: RTL

- Receiving end of the conv output stream (data/valid/running, as driven by conv_top or a chained conv pair).
- Captures one M×M result frame, in raster order, into internal storage.
- Flags frame completion and framing errors.
- Exposes a synchronous random-access read port so a host/debug reader can drain the frame after capture.

---
 rtl/conv_pkg.sv | 24 ++
 rtl/conv_sink_ram.sv | 42 ++++
 rtl/conv_result_sink.sv | 132 +++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the conv result sink: FSM encoding, error-bit
// positions and the frame-size helper.
package conv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DONE    = 2'd2
   } sink_state_t;

   // Bit positions inside the sticky error vector.
   localparam int ERR_OVF   = 0;
   localparam int ERR_SHORT = 1;

   // Default feature-map side and the matching frame length.
   localparam int M_DEFAULT = 4;
   localparam int FRAME     = M_DEFAULT * M_DEFAULT;

   // Number of samples in one M x M output frame.
   function automatic int frame_size(input int m);
      return m * m;
   endfunction

endpackage

// File: rtl/conv_sink_ram.sv
// Simple dual-port frame store: one write port, one registered read port.
// The read register can be forced to zero for indices outside the frame.
module conv_sink_ram #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  rd_en_i,
   input  logic                  rd_clr_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q;

   // Storage is never cleared; only written samples are meaningful.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Registered read; sees the pre-write contents on a same-address collision
   // and holds its value when no read is requested.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else if (rd_en_i) begin
         rd_data_q <= rd_clr_i ? '0 : mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/conv_result_sink.sv
// Receiving end of the conv output stream: captures one M x M frame in
// raster order, flags completion / framing errors and offers a random-access
// read port for draining the frame.
module conv_result_sink
   import conv_pkg::*;
#(
   parameter int M          = 4,
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  valid_i,
   input  logic                  running_i,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic [ADDR_WIDTH:0]   count_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [1:0]            err_o
);

   localparam int                FRAME_LEN = frame_size(M);
   localparam logic [ADDR_WIDTH:0] FRAME_CNT = (ADDR_WIDTH+1)'(FRAME_LEN);
   localparam logic [ADDR_WIDTH:0] LAST_IDX  = (ADDR_WIDTH+1)'(FRAME_LEN - 1);

   sink_state_t           state_q, state_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic [1:0]            err_q, err_d;
   logic                  run_q;
   logic                  rd_valid_q;
   logic                  wr_en;
   logic                  rd_clr;
   logic                  run_fall;

   // Upstream running dropped since last cycle.
   assign run_fall = run_q & ~running_i;
   // Indices past the end of the frame read back as zero.
   assign rd_clr   = ({1'b0, rd_addr} >= FRAME_CNT);

   // State, counter, error flags, running history and read-valid pipeline.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         err_q      <= '0;
         run_q      <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         err_q      <= err_d;
         run_q      <= running_i;
         rd_valid_q <= rd_en;
      end
   end

   // Next-state, counter and error logic; start always wins over a sample
   // arriving in the same cycle.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      err_d   = err_q;
      wr_en   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_CAPTURE;
               count_d = '0;
               err_d   = '0;
            end
         end
         ST_CAPTURE: begin
            if (start) begin
               count_d = '0;
               err_d   = '0;
            end else begin
               if (valid_i) begin
                  wr_en   = 1'b1;
                  count_d = count_q + 1'b1;
                  if (count_q == LAST_IDX) begin
                     state_d = ST_DONE;
                  end
               end
               // A sample coinciding with the falling edge is already counted.
               if (run_fall && (count_d < FRAME_CNT)) begin
                  err_d[ERR_SHORT] = 1'b1;
                  state_d          = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (start) begin
               state_d = ST_CAPTURE;
               count_d = '0;
               err_d   = '0;
            end else if (valid_i) begin
               err_d[ERR_OVF] = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   conv_sink_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk       (clk),
      .rst_n     (rst),
      .wr_en_i   (wr_en),
      .wr_addr_i (count_q[ADDR_WIDTH-1:0]),
      .wr_data_i (data_i),
      .rd_en_i   (rd_en),
      .rd_clr_i  (rd_clr),
      .rd_addr_i (rd_addr),
      .rd_data_o (rd_data)
   );

   assign rd_valid = rd_valid_q;
   assign count_o  = count_q;
   assign busy_o   = (state_q == ST_CAPTURE);
   assign done_o   = (state_q == ST_DONE);
   assign err_o    = err_q;

endmodule
